// File: rtl/mem_bus_resp_pkg.sv
// rtl/mem_bus_resp_pkg.sv - shared types and constants for the memory/IO responder
package mem_bus_resp_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    MBR_IDLE = 2'd0,
    MBR_C1   = 2'd1,
    MBR_C2   = 2'd2,
    MBR_DONE = 2'd3
  } mbr_state_e;

  // Byte-lane select patterns ([0]=even byte, [1]=odd byte)
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_EVEN = 2'b01;
  localparam logic [1:0] SEL_ODD  = 2'b10;
  localparam logic [1:0] SEL_WORD = 2'b11;

  // Source for the upper byte of memout when it is written
  typedef enum logic [1:0] {
    HI_DAT_HI = 2'd0,
    HI_ZERO   = 2'd1,
    HI_DAT_LO = 2'd2
  } hi_src_e;

  // How one bus phase's read data is merged into memout
  typedef struct packed {
    logic    lo_we;
    logic    lo_from_hi;
    logic    hi_we;
    hi_src_e hi_src;
  } merge_t;

  localparam merge_t MERGE_NONE = '{lo_we: 1'b0, lo_from_hi: 1'b0, hi_we: 1'b0, hi_src: HI_DAT_HI};

  // Apply one phase's byte-merge to the current memout value
  function automatic logic [15:0] merge_memout(input merge_t m, input logic [15:0] cur,
                                               input logic [15:0] dat);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = cur[7:0];
    hi = cur[15:8];
    if (m.lo_we) lo = m.lo_from_hi ? dat[15:8] : dat[7:0];
    if (m.hi_we) begin
      case (m.hi_src)
        HI_DAT_HI: hi = dat[15:8];
        HI_DAT_LO: hi = dat[7:0];
        default:   hi = 8'h00;
      endcase
    end
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mem_bus_resp_if.sv
// rtl/mem_bus_resp_if.sv - Wishbone-classic 16-bit bus bundle between responder and system bus
interface mem_bus_resp_if;
  logic [18:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_tga_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/mem_bus_resp_lane_align.sv
// rtl/mem_bus_resp_lane_align.sv - byte-lane steering for one bus phase of an access
module mem_bus_resp_lane_align
  import mem_bus_resp_pkg::*;
(
  input  logic        addr_lsb_i,
  input  logic        byteop_i,
  input  logic        phase2_i,
  input  logic [15:0] wr_data_i,
  output logic [1:0]  sel_o,
  output logic [15:0] dat_o,
  output merge_t      merge_o
);

  // Lane select, write data placement and memout merge for the phase being loaded
  always_comb begin
    sel_o              = SEL_WORD;
    dat_o              = wr_data_i;
    merge_o.lo_we      = 1'b1;
    merge_o.lo_from_hi = 1'b0;
    merge_o.hi_we      = 1'b1;
    merge_o.hi_src     = HI_DAT_HI;
    if (byteop_i) begin
      merge_o.hi_src = HI_ZERO;
      if (addr_lsb_i) begin
        sel_o              = SEL_ODD;
        dat_o              = {wr_data_i[7:0], 8'h00};
        merge_o.lo_from_hi = 1'b1;
      end else begin
        sel_o = SEL_EVEN;
        dat_o = {8'h00, wr_data_i[7:0]};
      end
    end else if (addr_lsb_i) begin
      // Odd word: low byte travels on the odd lane first, high byte on the next even lane
      if (!phase2_i) begin
        sel_o              = SEL_ODD;
        dat_o              = {wr_data_i[7:0], 8'h00};
        merge_o.lo_from_hi = 1'b1;
        merge_o.hi_we      = 1'b0;
      end else begin
        sel_o          = SEL_EVEN;
        dat_o          = {8'h00, wr_data_i[15:8]};
        merge_o.lo_we  = 1'b0;
        merge_o.hi_src = HI_DAT_LO;
      end
    end
  end

endmodule

// File: rtl/mem_bus_resp.sv
// rtl/mem_bus_resp.sv - exec-stage memory/IO responder driving a 16-bit Wishbone-classic bus
module mem_bus_resp
  import mem_bus_resp_pkg::*;
#(
  parameter int TOUT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cpu_req,
  input  logic [19:0]    addr,
  input  logic [15:0]    wr_data,
  input  logic           we,
  input  logic           m_io,
  input  logic           byteop,
  output logic [15:0]    memout,
  output logic           block,
  mem_bus_resp_if.master wb
);

  localparam logic [TOUT_W-1:0] TOUT_ONE  = {{(TOUT_W-1){1'b0}}, 1'b1};
  // Phase is abandoned on the edge where the count would reach all-ones
  localparam logic [TOUT_W-1:0] TOUT_LAST = {{(TOUT_W-1){1'b1}}, 1'b0};

  mbr_state_e        state_q;
  logic [18:0]       wb_adr_q;
  logic [15:0]       wb_dat_q;
  logic [1:0]        wb_sel_q;
  logic              wb_we_q;
  logic              wb_tga_q;
  logic              wb_cyc_q;
  logic              wb_stb_q;
  logic [15:0]       memout_q;
  logic [TOUT_W-1:0] tout_q;
  merge_t            merge_q;

  logic [1:0]        lane_sel;
  logic [15:0]       lane_dat;
  merge_t            lane_merge;
  logic              split;
  logic              expire;
  logic              phase_end;
  logic [15:0]       rd_data;
  logic [18:0]       adr_first;
  logic [18:0]       adr_next;

  // Lane steering is always computed for the phase about to be loaded: C1 from IDLE, C2 from C1
  mem_bus_resp_lane_align u_lane_align (
    .addr_lsb_i (addr[0]),
    .byteop_i   (byteop),
    .phase2_i   (state_q == MBR_C1),
    .wr_data_i  (wr_data),
    .sel_o      (lane_sel),
    .dat_o      (lane_dat),
    .merge_o    (lane_merge)
  );

  assign split     = addr[0] & ~byteop;
  assign expire    = ~wb.wb_ack_i & (tout_q == TOUT_LAST);
  assign phase_end = wb.wb_ack_i | expire;
  assign rd_data   = wb.wb_ack_i ? wb.wb_dat_i : 16'hFFFF;
  // IO space is 16 bits wide, so its word address and increment live in [14:0]
  assign adr_first = m_io ? {3'b000, addr[15:1]} : addr[19:1];
  assign adr_next  = m_io ? {3'b000, wb_adr_q[14:0] + 15'd1} : wb_adr_q + 19'd1;

  // Access sequencer with registered bus outputs, timeout counter and read-data merge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MBR_IDLE;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      wb_sel_q <= SEL_NONE;
      wb_we_q  <= 1'b0;
      wb_tga_q <= 1'b0;
      wb_cyc_q <= 1'b0;
      wb_stb_q <= 1'b0;
      memout_q <= '0;
      tout_q   <= '0;
      merge_q  <= MERGE_NONE;
    end else begin
      case (state_q)
        MBR_IDLE: begin
          if (cpu_req) begin
            state_q  <= MBR_C1;
            wb_adr_q <= adr_first;
            wb_dat_q <= lane_dat;
            wb_sel_q <= lane_sel;
            wb_we_q  <= we;
            wb_tga_q <= m_io;
            wb_cyc_q <= 1'b1;
            wb_stb_q <= 1'b1;
            tout_q   <= '0;
            merge_q  <= lane_merge;
          end
        end
        MBR_C1, MBR_C2: begin
          if (phase_end) begin
            // A request withdrawn mid-access keeps nothing and skips any second phase
            if (!wb_we_q && cpu_req) begin
              memout_q <= merge_memout(merge_q, memout_q, rd_data);
            end
            if (cpu_req && (state_q == MBR_C1) && split) begin
              state_q  <= MBR_C2;
              wb_adr_q <= adr_next;
              wb_dat_q <= lane_dat;
              wb_sel_q <= lane_sel;
              tout_q   <= '0;
              merge_q  <= lane_merge;
            end else begin
              state_q  <= cpu_req ? MBR_DONE : MBR_IDLE;
              wb_cyc_q <= 1'b0;
              wb_stb_q <= 1'b0;
            end
          end else begin
            tout_q <= tout_q + TOUT_ONE;
          end
        end
        default: begin
          state_q <= MBR_IDLE;
        end
      endcase
    end
  end

  assign block       = cpu_req & (state_q != MBR_DONE) & ~rst;
  assign memout      = memout_q;
  assign wb.wb_adr_o = wb_adr_q;
  assign wb.wb_dat_o = wb_dat_q;
  assign wb.wb_sel_o = wb_sel_q;
  assign wb.wb_we_o  = wb_we_q;
  assign wb.wb_tga_o = wb_tga_q;
  assign wb.wb_cyc_o = wb_cyc_q;
  assign wb.wb_stb_o = wb_stb_q;

endmodule

// File: tb/tb_mem_bus_resp.sv
// tb/tb_mem_bus_resp.sv - directed self-checking bench for mem_bus_resp
module tb_mem_bus_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [19:0] addr;
  logic [15:0] wr_data;
  logic        we;
  logic        m_io;
  logic        byteop;
  logic [15:0] memout;
  logic        block;

  mem_bus_resp_if wb ();

  mem_bus_resp #(.TOUT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .addr    (addr),
    .wr_data (wr_data),
    .we      (we),
    .m_io    (m_io),
    .byteop  (byteop),
    .memout  (memout),
    .block   (block),
    .wb      (wb)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave model: acks after slv_wait wait states per phase, logs every accepted phase
  int          slv_wait  = 0;
  bit          slv_never = 1'b0;
  bit          slv_stray = 1'b0;
  logic [15:0] slv_rdata = 16'h0000;
  int          wcnt      = 0;
  bit          acc       = 1'b0;
  int          log_n     = 0;
  logic [18:0] log_adr [0:63];
  logic [15:0] log_dat [0:63];
  logic [1:0]  log_sel [0:63];
  logic        log_we  [0:63];
  logic        log_tga [0:63];

  assign wb.wb_dat_i = slv_rdata;

  always @(negedge clk) begin
    acc = wb.wb_stb_o && wb.wb_ack_i;
    if (acc) begin
      log_adr[log_n % 64] = wb.wb_adr_o;
      log_dat[log_n % 64] = wb.wb_dat_o;
      log_sel[log_n % 64] = wb.wb_sel_o;
      log_we[log_n % 64]  = wb.wb_we_o;
      log_tga[log_n % 64] = wb.wb_tga_o;
      log_n++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!wb.wb_stb_o) begin
      wcnt = 0;
      wb.wb_ack_i = slv_stray;
    end else begin
      if (acc) wcnt = 0;
      wb.wb_ack_i = !slv_never && (wcnt >= slv_wait);
      wcnt++;
    end
  end

  // One complete access; returns in the DONE cycle with cpu_req already withdrawn
  task automatic do_access(input string tag, input logic [19:0] a, input logic [15:0] wd,
                           input logic w, input logic io, input logic bo, output int blk);
    bit done;
    done = 1'b0;
    blk  = 0;
    @(negedge clk);
    addr = a; wr_data = wd; we = w; m_io = io; byteop = bo; cpu_req = 1'b1;
    for (int i = 0; i < 600; i++) begin
      #1;
      if (!block) begin
        done = 1'b1;
        break;
      end
      blk++;
      @(negedge clk);
    end
    cpu_req = 1'b0;
    check_eq({tag, "_completes"}, {31'd0, done}, 32'd1);
  endtask

  int blk;
  int base;

  initial begin
    rst = 1'b1; cpu_req = 1'b1; addr = '0; wr_data = '0; we = 1'b0; m_io = 1'b0; byteop = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_block", {31'd0, block}, 32'd0);
    check_eq("rst_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
    check_eq("rst_stb", {31'd0, wb.wb_stb_o}, 32'd0);
    check_eq("rst_sel", {30'd0, wb.wb_sel_o}, 32'd0);
    check_eq("rst_adr", {13'd0, wb.wb_adr_o}, 32'd0);
    check_eq("rst_dat", {16'd0, wb.wb_dat_o}, 32'd0);
    check_eq("rst_memout", {16'd0, memout}, 32'd0);
    cpu_req = 1'b0;
    rst = 1'b0;

    // 1: aligned word read, zero-wait slave
    slv_wait = 0; slv_rdata = 16'hBEEF; base = log_n;
    do_access("t1", 20'h01000, 16'h0000, 1'b0, 1'b0, 1'b0, blk);
    check_eq("t1_blk", blk, 2);
    check_eq("t1_memout", {16'd0, memout}, 32'h0000BEEF);
    check_eq("t1_cyc_done", {31'd0, wb.wb_cyc_o}, 32'd0);
    check_eq("t1_nphase", log_n - base, 1);
    check_eq("t1_adr", {13'd0, log_adr[base % 64]}, 32'h00800);
    check_eq("t1_sel", {30'd0, log_sel[base % 64]}, 32'h3);

    // 2: odd word write split into two byte cycles, one wait state each
    slv_wait = 1; base = log_n;
    do_access("t2", 20'h00101, 16'h1234, 1'b1, 1'b0, 1'b0, blk);
    check_eq("t2_blk", blk, 5);
    check_eq("t2_nphase", log_n - base, 2);
    check_eq("t2_c1_adr", {13'd0, log_adr[base % 64]}, 32'h080);
    check_eq("t2_c1_sel", {30'd0, log_sel[base % 64]}, 32'h2);
    check_eq("t2_c1_dat", {16'd0, log_dat[base % 64]}, 32'h3400);
    check_eq("t2_c1_we", {31'd0, log_we[base % 64]}, 32'd1);
    check_eq("t2_c2_adr", {13'd0, log_adr[(base + 1) % 64]}, 32'h081);
    check_eq("t2_c2_sel", {30'd0, log_sel[(base + 1) % 64]}, 32'h1);
    check_eq("t2_c2_dat", {16'd0, log_dat[(base + 1) % 64]}, 32'h0012);
    check_eq("t2_memout_kept", {16'd0, memout}, 32'h0000BEEF);

    // 3: byte accesses on both lanes
    slv_wait = 0; slv_rdata = 16'hA55A; base = log_n;
    do_access("t3r", 20'h00203, 16'h0000, 1'b0, 1'b0, 1'b1, blk);
    check_eq("t3r_sel", {30'd0, log_sel[base % 64]}, 32'h2);
    check_eq("t3r_adr", {13'd0, log_adr[base % 64]}, 32'h101);
    check_eq("t3r_memout", {16'd0, memout}, 32'h00A5);
    base = log_n;
    do_access("t3e", 20'h00202, 16'h0000, 1'b0, 1'b0, 1'b1, blk);
    check_eq("t3e_sel", {30'd0, log_sel[base % 64]}, 32'h1);
    check_eq("t3e_memout", {16'd0, memout}, 32'h005A);
    base = log_n;
    do_access("t3w", 20'h00202, 16'hFF77, 1'b1, 1'b0, 1'b1, blk);
    check_eq("t3w_sel", {30'd0, log_sel[base % 64]}, 32'h1);
    check_eq("t3w_dat", {16'd0, log_dat[base % 64]}, 32'h0077);
    check_eq("t3w_memout_kept", {16'd0, memout}, 32'h005A);

    // 4: IO odd word at port 0xFFFF wraps in 16 bits; memory odd word at 0xFFFFF wraps in 20
    base = log_n;
    do_access("t4io", 20'hFFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, blk);
    check_eq("t4io_nphase", log_n - base, 2);
    check_eq("t4io_c1_adr", {13'd0, log_adr[base % 64]}, 32'h07FFF);
    check_eq("t4io_c1_sel", {30'd0, log_sel[base % 64]}, 32'h2);
    check_eq("t4io_c1_tga", {31'd0, log_tga[base % 64]}, 32'd1);
    check_eq("t4io_c2_adr", {13'd0, log_adr[(base + 1) % 64]}, 32'h00000);
    check_eq("t4io_c2_sel", {30'd0, log_sel[(base + 1) % 64]}, 32'h1);
    check_eq("t4io_memout", {16'd0, memout}, 32'h5AA5);
    slv_rdata = 16'h1234; base = log_n;
    do_access("t4m", 20'hFFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, blk);
    check_eq("t4m_c1_adr", {13'd0, log_adr[base % 64]}, 32'h7FFFF);
    check_eq("t4m_c1_tga", {31'd0, log_tga[base % 64]}, 32'd0);
    check_eq("t4m_c2_adr", {13'd0, log_adr[(base + 1) % 64]}, 32'h00000);
    check_eq("t4m_memout", {16'd0, memout}, 32'h3412);

    // 5: silent slave, phase abandoned after 255 unacked clocks
    slv_never = 1'b1;
    do_access("t5", 20'h00400, 16'h0000, 1'b0, 1'b0, 1'b0, blk);
    check_eq("t5_blk", blk, 256);
    check_eq("t5_memout", {16'd0, memout}, 32'hFFFF);
    slv_never = 1'b0;

    // Ack outside a bus cycle is ignored
    slv_stray = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("stray_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
    check_eq("stray_memout", {16'd0, memout}, 32'hFFFF);
    slv_stray = 1'b0;
    repeat (2) @(negedge clk);

    // Request withdrawn during C1 of a split read: C1 finishes, C2 skipped, data discarded
    slv_wait = 2; slv_rdata = 16'h9876; base = log_n;
    addr = 20'h00301; we = 1'b0; m_io = 1'b0; byteop = 1'b0; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    check_eq("drop_block", {31'd0, block}, 32'd0);
    repeat (8) @(negedge clk);
    check_eq("drop_nphase", log_n - base, 1);
    check_eq("drop_c1_adr", {13'd0, log_adr[base % 64]}, 32'h180);
    check_eq("drop_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
    check_eq("drop_memout", {16'd0, memout}, 32'hFFFF);

    // 6: reset during C2 of a split write, then a clean access
    slv_wait = 3;
    addr = 20'h00101; wr_data = 16'h1234; we = 1'b1; cpu_req = 1'b1;
    begin
      bit in_c2;
      in_c2 = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (wb.wb_cyc_o && (wb.wb_sel_o == 2'b01)) begin
          in_c2 = 1'b1;
          break;
        end
      end
      check_eq("t6_reach_c2", {31'd0, in_c2}, 32'd1);
    end
    rst = 1'b1;
    #1;
    check_eq("t6_block_in_rst", {31'd0, block}, 32'd0);
    @(negedge clk);
    check_eq("t6_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
    check_eq("t6_stb", {31'd0, wb.wb_stb_o}, 32'd0);
    rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check_eq("t6_idle_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
    slv_wait = 0; slv_rdata = 16'h0F0F; base = log_n;
    do_access("t6n", 20'h00002, 16'h0000, 1'b0, 1'b0, 1'b0, blk);
    check_eq("t6n_blk", blk, 2);
    check_eq("t6n_adr", {13'd0, log_adr[base % 64]}, 32'h00001);
    check_eq("t6n_memout", {16'd0, memout}, 32'h0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
